// File: rtl/lstm_seq_ctrl.sv
// Run sequencer for the LSTM accelerator: turns the APB control word into one-shot
// multi-step runs on a valid/ready engine handshake, with abort, timeout and irq.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP_W     = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [DATA_WIDTH-1:0] ctrl_word,
  output logic [DATA_WIDTH-1:0] status_word,
  output logic                  step_valid,
  output logic [STEP_W-1:0]     step_idx,
  input  logic                  step_ready,
  input  logic                  step_done,
  output logic                  irq,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int WAIT_W = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_t                  state_q, state_d;
  logic                    start_prev_q;
  logic                    step_valid_q, step_valid_d;
  logic [STEP_W-1:0]       step_idx_q, step_idx_d;
  logic [STEP_W-1:0]       num_steps_q, num_steps_d;
  logic [STEP_W-1:0]       steps_done_q, steps_done_d;
  logic [15:0]             cycles_q, cycles_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    err_zero_q, err_zero_d;
  logic                    err_timeout_q, err_timeout_d;
  logic [DATA_WIDTH-1:0]   status_q, status_d;
  logic [15:0]             steps_ext;

  logic              start_edge;
  logic              abort_req;
  logic [STEP_W-1:0] num_steps_in;
  logic              unused_bits;

  assign start_edge   = ctrl_word[0] & ~start_prev_q;
  assign abort_req    = ctrl_word[1];
  assign num_steps_in = ctrl_word[8 +: STEP_W];
  assign unused_bits  = ^{ctrl_word[DATA_WIDTH-1:8+STEP_W], ctrl_word[7:3], steps_ext[15:8]};

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= S_IDLE;
      start_prev_q  <= 1'b1;
      step_valid_q  <= 1'b0;
      step_idx_q    <= '0;
      num_steps_q   <= '0;
      steps_done_q  <= '0;
      cycles_q      <= '0;
      wait_cnt_q    <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_zero_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      status_q      <= '0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= ctrl_word[0];
      step_valid_q  <= step_valid_d;
      step_idx_q    <= step_idx_d;
      num_steps_q   <= num_steps_d;
      steps_done_q  <= steps_done_d;
      cycles_q      <= cycles_d;
      wait_cnt_q    <= wait_cnt_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      err_zero_q    <= err_zero_d;
      err_timeout_q <= err_timeout_d;
      status_q      <= status_d;
    end
  end

  // Handshake: a step request transfers on the cycle step_valid & step_ready are both high;
  // step_valid then stays low until the engine's step_done for that step is seen in WAIT.
  always_comb begin
    state_d       = state_q;
    step_idx_d    = step_idx_q;
    num_steps_d   = num_steps_q;
    steps_done_d  = steps_done_q;
    cycles_d      = cycles_q;
    wait_cnt_d    = wait_cnt_q;
    done_d        = done_q;
    aborted_d     = aborted_q;
    err_zero_d    = err_zero_q;
    err_timeout_d = err_timeout_q;

    if (state_q != S_IDLE && cycles_q != 16'hFFFF) begin
      cycles_d = cycles_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          if (num_steps_in == '0) begin
            err_zero_d = 1'b1;
          end else begin
            num_steps_d   = num_steps_in;
            done_d        = 1'b0;
            aborted_d     = 1'b0;
            err_zero_d    = 1'b0;
            err_timeout_d = 1'b0;
            steps_done_d  = '0;
            cycles_d      = '0;
            step_idx_d    = '0;
            state_d       = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (abort_req) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (step_ready) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Abort wins over a same-cycle step_done, which is then not counted.
        if (abort_req) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (step_done) begin
          steps_done_d = steps_done_q + STEP_W'(1);
          if (steps_done_d == num_steps_q) begin
            state_d = S_DONE;
          end else begin
            step_idx_d = step_idx_q + STEP_W'(1);
            state_d    = S_ISSUE;
          end
        end else if (TIMEOUT != 0 && wait_cnt_q == TIMEOUT_CNT) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else if (TIMEOUT != 0) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    step_valid_d = (state_d == S_ISSUE);

    steps_ext        = 16'(steps_done_d);
    status_d         = '0;
    status_d[0]      = (state_d == S_ISSUE) || (state_d == S_WAIT);
    status_d[1]      = done_d;
    status_d[2]      = aborted_d;
    status_d[3]      = err_zero_d;
    status_d[4]      = err_timeout_d;
    status_d[15:8]   = steps_ext[7:0];
    status_d[31:16]  = cycles_d;
  end

  assign status_word = status_q;
  assign step_valid  = step_valid_q;
  assign step_idx    = step_idx_q;
  assign dbg_state_o = state_q;
  assign irq         = ctrl_word[2] & (done_q | aborted_q | err_zero_q | err_timeout_q);

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: directed run table, multi-cycle corner sequences and
// randomized runs checked against a transaction-level model of run length and status.
module tb_lstm_seq_ctrl;
  localparam int DW = 32;
  localparam int SW = 8;
  localparam int TO = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [DW-1:0] ctrl_word;
  logic [DW-1:0] status_word;
  logic          step_valid;
  logic [SW-1:0] step_idx;
  logic          step_ready;
  logic          step_done;
  logic          irq;
  logic [1:0]    dbg_state;

  lstm_seq_ctrl #(.DATA_WIDTH(DW), .STEP_W(SW), .TIMEOUT(TO)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .ctrl_word  (ctrl_word),
    .status_word(status_word),
    .step_valid (step_valid),
    .step_idx   (step_idx),
    .step_ready (step_ready),
    .step_done  (step_done),
    .irq        (irq),
    .dbg_state_o(dbg_state)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q[$];
  int rd_a[16];
  int dd_a[16];

  typedef struct {
    int          n;
    bit          irq_en;
    int          rd;
    int          dd;
    logic [31:0] exp_status;
    bit          exp_irq;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input bit st, input bit ab, input bit ie, input int n);
    logic [DW-1:0] w;
    w = '0;
    w[0] = st;
    w[1] = ab;
    w[2] = ie;
    w[8 +: SW] = SW'(n);
    return w;
  endfunction

  // One complete run: rd_a[i] cycles of ready-low and dd_a[i] wait cycles before step_done.
  task automatic do_run(input int n, input bit ie, input logic [DW-1:0] exp_status,
                        input bit exp_irq, input string tag);
    ctrl_word  = mk(1'b0, 1'b0, ie, n);
    step_ready = 1'b0;
    step_done  = 1'b0;
    tick;
    ctrl_word = mk(1'b1, 1'b0, ie, n);
    for (int i = 0; i < n; i++) exp_q.push_back(SW'(i));
    tick;
    ctrl_word = mk(1'b1, 1'b0, ie, int'($urandom_range(0, 255)));
    check({tag, " busy_after_start"}, DW'(status_word[0]), 1);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < rd_a[i]; k++) begin
        step_done = 1'($urandom_range(0, 1));
        check({tag, " valid_hold"}, DW'(step_valid), 1);
        if (exp_q.size() != 0) check({tag, " idx_hold"}, DW'(step_idx), DW'(exp_q[0]));
        tick;
      end
      step_done  = 1'b0;
      step_ready = 1'b1;
      check({tag, " valid_at_hs"}, DW'(step_valid), 1);
      if (exp_q.size() != 0) check({tag, " idx_at_hs"}, DW'(step_idx), DW'(exp_q.pop_front()));
      tick;
      step_ready = 1'b0;
      for (int k = 0; k < dd_a[i]; k++) tick;
      step_done = 1'b1;
      tick;
      step_done = 1'b0;
    end
    tick;
    check({tag, " status"}, status_word, exp_status);
    check({tag, " irq"}, DW'(irq), DW'(exp_irq));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cyc;
    bit ie;

    vecs[0] = '{3, 1'b1, 0, 1, 32'h000A0302, 1'b1};
    vecs[1] = '{1, 1'b0, 2, 0, 32'h00050102, 1'b0};
    vecs[2] = '{5, 1'b1, 1, 3, 32'h001F0502, 1'b1};
    vecs[3] = '{2, 1'b0, 5, 0, 32'h000F0202, 1'b0};

    // start held high through and after reset must not launch
    PRESET     = 1'b1;
    ctrl_word  = mk(1'b1, 1'b0, 1'b1, 3);
    step_ready = 1'b1;
    step_done  = 1'b0;
    repeat (3) tick;
    check("reset status", status_word, 0);
    check("reset valid", DW'(step_valid), 0);
    check("reset idx", DW'(step_idx), 0);
    check("reset irq", DW'(irq), 0);
    check("reset state", DW'(dbg_state), 0);
    PRESET = 1'b0;
    repeat (3) begin
      tick;
      check("post_reset no_launch", status_word, 0);
      check("post_reset valid", DW'(step_valid), 0);
    end

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) begin
        rd_a[i] = vecs[v].rd;
        dd_a[i] = vecs[v].dd;
      end
      do_run(vecs[v].n, vecs[v].irq_en, vecs[v].exp_status, vecs[v].exp_irq, $sformatf("vec%0d", v));
    end

    // abort together with step_done in WAIT of step 1
    ctrl_word = mk(1'b0, 1'b0, 1'b1, 4);
    tick;
    ctrl_word = mk(1'b1, 1'b0, 1'b1, 4);
    tick;
    step_ready = 1'b1;
    tick;
    step_ready = 1'b0;
    step_done  = 1'b1;
    tick;
    step_done = 1'b0;
    check("abort idx1", DW'(step_idx), 1);
    step_ready = 1'b1;
    tick;
    step_ready = 1'b0;
    step_done  = 1'b1;
    ctrl_word  = mk(1'b1, 1'b1, 1'b1, 4);
    tick;
    step_done = 1'b0;
    ctrl_word = mk(1'b1, 1'b0, 1'b1, 4);
    check("abort valid_drop", DW'(step_valid), 0);
    check("abort status", status_word, 32'h00040104);
    check("abort irq", DW'(irq), 1);
    repeat (3) tick;
    check("abort no_relaunch", status_word, 32'h00040104);
    ctrl_word = mk(1'b1, 1'b0, 1'b0, 4);
    #1;
    check("irq_en clear", DW'(irq), 0);

    // zero-step start
    ctrl_word = mk(1'b0, 1'b0, 1'b1, 0);
    tick;
    ctrl_word = mk(1'b1, 1'b0, 1'b1, 0);
    repeat (3) begin
      tick;
      check("zero err_zero", DW'(status_word[3]), 1);
      check("zero busy", DW'(status_word[0]), 0);
      check("zero valid", DW'(step_valid), 0);
    end
    check("zero irq", DW'(irq), 1);

    // timeout: 9 cycles after WAIT entry
    ctrl_word = mk(1'b0, 1'b0, 1'b0, 2);
    tick;
    ctrl_word = mk(1'b1, 1'b0, 1'b0, 2);
    tick;
    step_ready = 1'b1;
    tick;
    step_ready = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      tick;
      check($sformatf("timeout wait%0d", k), DW'(status_word[4:0]), 1);
    end
    tick;
    check("timeout status", status_word, 32'h000A0010);
    check("timeout state", DW'(dbg_state), 0);
    for (int i = 0; i < 16; i++) begin
      rd_a[i] = 0;
      dd_a[i] = 2;
    end
    do_run(2, 1'b0, 32'h00090202, 1'b0, "after_timeout");

    // randomized runs against a run-length model
    for (int r = 0; r < 8; r++) begin
      n   = int'($urandom_range(1, 6));
      ie  = 1'($urandom_range(0, 1));
      cyc = 1;
      for (int i = 0; i < n; i++) begin
        rd_a[i] = int'($urandom_range(0, 3));
        dd_a[i] = int'($urandom_range(0, TO - 1));
        cyc += rd_a[i] + 1 + dd_a[i] + 1;
      end
      do_run(n, ie, (DW'(cyc) << 16) | (DW'(n) << 8) | DW'(2), ie, $sformatf("rand%0d", r));
    end

    // reset in the middle of WAIT for step 1
    ctrl_word = mk(1'b0, 1'b0, 1'b1, 3);
    tick;
    ctrl_word = mk(1'b1, 1'b0, 1'b1, 3);
    tick;
    step_ready = 1'b1;
    tick;
    step_ready = 1'b0;
    step_done  = 1'b1;
    tick;
    step_done  = 1'b0;
    step_ready = 1'b1;
    tick;
    step_ready = 1'b0;
    tick;
    check("midrun idx", DW'(step_idx), 1);
    PRESET = 1'b1;
    tick;
    check("midrun reset status", status_word, 0);
    check("midrun reset valid", DW'(step_valid), 0);
    check("midrun reset idx", DW'(step_idx), 0);
    check("midrun reset irq", DW'(irq), 0);
    check("midrun reset state", DW'(dbg_state), 0);
    PRESET = 1'b0;
    repeat (2) tick;
    check("midrun no_launch", DW'(status_word[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
